// File: rtl/multi_issue_queue_if.sv
// Handshake bundle for multi_issue_queue.
//   master: producer/consumer side. Drives enq_valid, enq_data, deq_take and flush.
//           Observes enq_ready, deq_valid, deq_data, count and almost_full.
//   slave : the queue itself, with the opposite directions.
// Lane packing: lane i occupies bits [i*DATA_W +: DATA_W], and lane 0 is the oldest.
interface multi_issue_queue_if #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ENQ_W  = 2,
  parameter int unsigned DEQ_W  = 2,
  parameter int unsigned DATA_W = 128
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(DEQ_W + 1);

  logic [ENQ_W-1:0]        enq_valid;
  logic [ENQ_W*DATA_W-1:0] enq_data;
  logic                    enq_ready;
  logic [DEQ_W-1:0]        deq_valid;
  logic [DEQ_W*DATA_W-1:0] deq_data;
  logic [TW-1:0]           deq_take;
  logic                    flush;
  logic [CW-1:0]           count;
  logic                    almost_full;

  modport master (
    output enq_valid, enq_data, deq_take, flush,
    input  enq_ready, deq_valid, deq_data, count, almost_full
  );

  modport slave (
    input  enq_valid, enq_data, deq_take, flush,
    output enq_ready, deq_valid, deq_data, count, almost_full
  );
endinterface

// File: rtl/multi_issue_queue.sv
// Multi-lane issue queue. It is a circular buffer that accepts up to ENQ_W entries and
// issues up to DEQ_W entries per cycle. When BYPASS is set, entries arriving this cycle
// can be forwarded straight to free issue lanes.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   q     : multi_issue_queue_if.slave. It carries the enqueue lanes and enq_ready, the
//           issue candidates and deq_take, flush, count and almost_full.
module multi_issue_queue #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ENQ_W  = 2,
  parameter int unsigned DEQ_W  = 2,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BYPASS = 1
) (
  input logic             clk,
  input logic             reset,
  multi_issue_queue_if.slave q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic        blocked, seen_gap;
  int unsigned k, n_stored, n_valid, take, b;

  always_comb begin
    blocked     = reset | q.flush;
    // Uses only the registered count, so there is no path from deq_take to enq_ready.
    q.enq_ready = ~blocked & ((DEPTH - 32'(count_q)) >= ENQ_W);

    // Accepted lanes form the valid prefix that ends at the first zero.
    k        = 0;
    seen_gap = 1'b0;
    for (int i = 0; i < int'(ENQ_W); i++) begin
      if (!q.enq_valid[i]) begin
        seen_gap = 1'b1;
      end else if (!seen_gap && q.enq_ready) begin
        k = k + 1;
      end
    end

    n_stored    = (32'(count_q) > DEQ_W) ? DEQ_W : 32'(count_q);
    n_valid     = 0;
    q.deq_valid = '0;
    q.deq_data  = '0;
    for (int i = 0; i < int'(DEQ_W); i++) begin
      int unsigned lane;
      lane = 32'(i) - n_stored;
      if (!blocked) begin
        if (32'(i) < n_stored) begin
          q.deq_valid[i]                  = 1'b1;
          q.deq_data[i*DATA_W +: DATA_W]  = mem_q[head_q + PW'(i)];
          n_valid                         = n_valid + 1;
        end else if (BYPASS != 0 && lane < k) begin
          q.deq_valid[i]                  = 1'b1;
          q.deq_data[i*DATA_W +: DATA_W]  = q.enq_data[lane*DATA_W +: DATA_W];
          n_valid                         = n_valid + 1;
        end
      end
    end

    // Clamp an over-request to the number of valid candidates.
    take = (32'(q.deq_take) > n_valid) ? n_valid : 32'(q.deq_take);
    // b counts the enqueue lanes that are issued directly and are never stored.
    b    = (take > 32'(count_q)) ? take - 32'(count_q) : 0;

    if (blocked) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(take - b);
      tail_d  = tail_q + PW'(k - b);
      count_d = CW'(32'(count_q) + k - take);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is never cleared. The valid lanes only reach live entries.
  always_ff @(posedge clk) begin
    for (int j = 0; j < int'(ENQ_W); j++) begin
      if (!blocked && 32'(j) >= b && 32'(j) < k) begin
        mem_q[tail_q + PW'(32'(j) - b)] <= q.enq_data[j*DATA_W +: DATA_W];
      end
    end
  end

  assign q.count       = count_q;
  assign q.almost_full = (DEPTH - 32'(count_q)) < (2 * ENQ_W);

endmodule

// File: tb/tb_multi_issue_queue.sv
module tb_multi_issue_queue;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ENQ_W  = 2;
  localparam int unsigned DEQ_W  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // qb drives the BYPASS=1 instance and qn drives the BYPASS=0 instance. Both get the same stimulus.
  multi_issue_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DATA_W(DATA_W)) qb ();
  multi_issue_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DATA_W(DATA_W)) qn ();

  multi_issue_queue #(
    .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DATA_W(DATA_W), .BYPASS(1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .q     (qb.slave)
  );

  multi_issue_queue #(
    .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DATA_W(DATA_W), .BYPASS(0)
  ) dut_n (
    .clk   (clk),
    .reset (reset),
    .q     (qn.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each queue holds the stored entries, oldest first.
  logic [DATA_W-1:0] mq [2][$];
  bit model_ok = 1'b0;

  task automatic chk(input string tag, input int w, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[dut%0d] got=%0h exp=%0h", tag, w, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] ev, input logic [DATA_W-1:0] d0,
                      input logic [DATA_W-1:0] d1, input logic [1:0] take,
                      input logic fl, input logic rs);
    logic [DATA_W-1:0] cand[$];
    logic [DATA_W-1:0] lane_d [2];
    logic              o_ready [2];
    logic [DEQ_W-1:0]  o_valid [2];
    logic [DEQ_W*DATA_W-1:0] o_data [2];
    logic [CW-1:0]     o_cnt [2];
    logic              o_af [2];
    int                k_m [2];
    int                take_m [2];
    logic              blocked;

    reset        = rs;
    qb.enq_valid = ev;  qb.enq_data = {d1, d0};  qb.deq_take = take;  qb.flush = fl;
    qn.enq_valid = ev;  qn.enq_data = {d1, d0};  qn.deq_take = take;  qn.flush = fl;
    lane_d[0] = d0;
    lane_d[1] = d1;
    blocked   = rs | fl;

    @(negedge clk);
    o_ready[0] = qb.enq_ready; o_valid[0] = qb.deq_valid; o_data[0] = qb.deq_data;
    o_cnt[0]   = qb.count;     o_af[0]    = qb.almost_full;
    o_ready[1] = qn.enq_ready; o_valid[1] = qn.deq_valid; o_data[1] = qn.deq_data;
    o_cnt[1]   = qn.count;     o_af[1]    = qn.almost_full;

    for (int w = 0; w < 2; w++) begin
      int sz;
      logic exp_ready;
      logic [DEQ_W-1:0] exp_valid;
      sz        = mq[w].size();
      exp_ready = !blocked && (int'(DEPTH) - sz >= int'(ENQ_W));
      k_m[w]    = 0;
      if (exp_ready && ev[0]) k_m[w] = ev[1] ? 2 : 1;
      cand.delete();
      if (!blocked) begin
        for (int i = 0; i < sz && i < int'(DEQ_W); i++) cand.push_back(mq[w][i]);
        if (w == 0)
          for (int j = 0; j < k_m[w] && cand.size() < DEQ_W; j++) cand.push_back(lane_d[j]);
      end
      exp_valid = '0;
      for (int i = 0; i < cand.size(); i++) exp_valid[i] = 1'b1;
      take_m[w] = (int'(take) > cand.size()) ? cand.size() : int'(take);

      chk("enq_ready", w, 64'(o_ready[w]), 64'(exp_ready));
      chk("deq_valid", w, 64'(o_valid[w]), 64'(exp_valid));
      for (int i = 0; i < cand.size(); i++)
        chk("deq_data", w, 64'(o_data[w][i*DATA_W +: DATA_W]), 64'(cand[i]));
      if (model_ok) begin
        chk("count", w, 64'(o_cnt[w]), 64'(sz));
        chk("almost_full", w, 64'(o_af[w]), 64'((int'(DEPTH) - sz) < int'(2 * ENQ_W)));
      end
    end

    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      if (blocked) begin
        mq[w].delete();
      end else begin
        for (int j = 0; j < k_m[w]; j++) mq[w].push_back(lane_d[j]);
        for (int t = 0; t < take_m[w]; t++) void'(mq[w].pop_front());
      end
    end
    if (rs) model_ok = 1'b1;
    #1;
  endtask

  task automatic idle();
    step(2'b00, '0, '0, 2'd0, 1'b0, 1'b0);
  endtask

  localparam logic [DATA_W-1:0] A = 32'hA000_000A;
  localparam logic [DATA_W-1:0] B = 32'hB000_000B;
  localparam logic [DATA_W-1:0] C = 32'hC000_000C;
  localparam logic [DATA_W-1:0] D = 32'hD000_000D;

  initial begin
    reset        = 1'b1;
    qb.enq_valid = '0; qb.enq_data = '0; qb.deq_take = '0; qb.flush = 1'b0;
    qn.enq_valid = '0; qn.enq_data = '0; qn.deq_take = '0; qn.flush = 1'b0;
    #1;

    // Reset held with the inputs active: the queue must not take or issue anything.
    step(2'b11, A, B, 2'd2, 1'b0, 1'b1);
    step(2'b11, A, B, 2'd2, 1'b0, 1'b1);

    // First cycle out of reset.
    idle();
    chk("post_reset_count", 0, 64'(qb.count), 64'd0);

    // Full bypass for dut0. dut1 (no bypass) stores A and B and issues nothing.
    step(2'b11, A, B, 2'd2, 1'b0, 1'b0);
    chk("full_bypass_count", 0, 64'(qb.count), 64'd0);
    chk("nobypass_count", 1, 64'(qn.count), 64'd2);
    idle();
    step(2'b00, '0, '0, 2'd0, 1'b1, 1'b0);

    // Partial bypass.
    step(2'b11, A, B, 2'd1, 1'b0, 1'b0);
    chk("partial_count1", 0, 64'(qb.count), 64'd1);
    step(2'b11, C, D, 2'd2, 1'b0, 1'b0);
    chk("partial_count2", 0, 64'(qb.count), 64'd1);
    idle();
    step(2'b00, '0, '0, 2'd0, 1'b1, 1'b0);

    // Fill to full, attempt one more enqueue, then drain across the wrap point.
    for (int i = 0; i < 5; i++) step(2'b11, 32'(16 + 2 * i), 32'(17 + 2 * i), 2'd0, 1'b0, 1'b0);
    chk("full_count", 0, 64'(qb.count), 64'd8);
    for (int i = 0; i < 4; i++) step(2'b00, '0, '0, 2'd2, 1'b0, 1'b0);
    chk("drain_count", 0, 64'(qb.count), 64'd0);
    // Make the pointers wrap again with traffic that mixes enqueue and issue.
    for (int i = 0; i < 6; i++) step(2'b11, 32'(100 + 2 * i), 32'(101 + 2 * i), 2'd1, 1'b0, 1'b0);

    // Flush with five entries stored, while an enqueue and a dequeue are also requested.
    step(2'b00, '0, '0, 2'd0, 1'b1, 1'b0);
    step(2'b11, 32'h51, 32'h52, 2'd0, 1'b0, 1'b0);
    step(2'b11, 32'h53, 32'h54, 2'd0, 1'b0, 1'b0);
    step(2'b01, 32'h55, 32'h0, 2'd0, 1'b0, 1'b0);
    chk("pre_flush_count", 0, 64'(qb.count), 64'd5);
    step(2'b11, 32'h56, 32'h57, 2'd2, 1'b1, 1'b0);
    idle();
    chk("post_flush_count", 0, 64'(qb.count), 64'd0);

    // Illegal requests: an enqueue with a gap at lane 0, and an over-sized take.
    step(2'b10, 32'h61, 32'h62, 2'd0, 1'b0, 1'b0);
    chk("gap_count", 0, 64'(qb.count), 64'd0);
    step(2'b01, 32'h63, 32'h0, 2'd0, 1'b0, 1'b0);
    step(2'b00, '0, '0, 2'd2, 1'b0, 1'b0);
    chk("overtake_count", 0, 64'(qb.count), 64'd0);
    step(2'b00, '0, '0, 2'd3, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      step(2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_issue_queue.md
MULTI_ISSUE_QUEUE -- requirements
Module: multi_issue_queue

Interface
REQ-001 Parameter DEPTH, default 32: number of queue entries; SHALL be a power of two and >= 2*max(ENQ_W,DEQ_W).
REQ-002 Parameter ENQ_W, default 2: enqueue lanes per cycle, legal range 1..4.
REQ-003 Parameter DEQ_W, default 2: issue (dequeue) lanes per cycle, legal range 1..4.
REQ-004 Parameter DATA_W, default 128: payload bits per entry (one decoded instruction).
REQ-005 Parameter BYPASS, default 1: 1 enables same-cycle enqueue-to-issue forwarding; 0 disables it.
REQ-006 Port list: one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enq_valid  in  ENQ_W  per-lane valid; lane 0 is oldest
- enq_data  in  ENQ_W*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- enq_ready  out  1  all ENQ_W lanes accepted this cycle
- deq_valid  out  DEQ_W  per-lane candidate valid; lane 0 is oldest
- deq_data  out  DEQ_W*DATA_W  candidate payloads, same lane packing
- deq_take  in  $clog2(DEQ_W+1)  number of candidates issued this cycle, counted from lane 0
- flush  in  1  discard all contents
- count  out  $clog2(DEPTH+1)  stored entries
- almost_full  out  1  free entries < 2*ENQ_W

Function
REQ-007 Storage SHALL be a DEPTH-entry circular buffer with head and tail pointers of width log2(DEPTH); pointers wrap modulo DEPTH.
REQ-008 The queue SHALL keep a registered occupancy count; full is count==DEPTH and empty is count==0, with no pointer-equality ambiguity.
REQ-009 enq_ready SHALL be (DEPTH-count) >= ENQ_W and SHALL NOT depend combinationally on deq_take, enq_valid or enq_data.
REQ-010 Enqueue lanes SHALL be prefix-contiguous. Accepted lanes are lanes 0..k-1, where k is the index of the first zero in enq_valid. Lanes after the first zero SHALL be ignored. k=0 when enq_ready=0.
REQ-011 Stored candidates: deq lane i < min(count,DEQ_W) SHALL be valid, with data mem[(head+i) mod DEPTH].
REQ-012 Bypassed candidates (BYPASS=1 only): deq lanes count..DEQ_W-1 SHALL be filled in order from accepted enqueue lanes 0..k-1, so deq_valid stays a contiguous prefix.
REQ-013 With BYPASS=0, deq lanes at or above count SHALL be invalid.
REQ-014 Effective take SHALL be min(deq_take, popcount(deq_valid)); an over-request SHALL be clamped, never underflow.
REQ-015 Bypassed lanes consumed, b = max(0, take - count). Enqueue lanes b..k-1 SHALL be written at tail, tail+1, and so on. Bypassed-and-issued lanes SHALL NOT be written.
REQ-016 Pointer and count update:
- head += min(take, count)
- tail += k - b
- count_next = count + k - take
REQ-017 Simultaneous enqueue and dequeue at full SHALL NOT free space for enqueue in the same cycle; this follows from REQ-009.
REQ-018 Flush SHALL have priority over enqueue and dequeue in the same cycle. On the next edge, head, tail and count SHALL become 0.
REQ-019 During a flush cycle, deq_valid SHALL be all-zero and enq_ready SHALL be 0.
REQ-020 almost_full SHALL be combinational from count.
REQ-021 Payload memory SHALL NOT be reset or cleared by flush; stale data SHALL never appear on a valid lane.
REQ-022 deq_data on invalid lanes is don't-care.

Reset
REQ-023 When reset is high at a rising edge, head, tail and count SHALL become 0, regardless of the other inputs.
REQ-024 While reset is high, enq_ready SHALL be 0 and deq_valid SHALL be all-zero.
REQ-025 In the first cycle after reset deasserts: count=0, enq_ready=1, almost_full=0.
REQ-026 Reset mid-operation SHALL discard all contents, identically to flush.

Verification
All scenarios use DEPTH=8, ENQ_W=2, DEQ_W=2, BYPASS=1 unless stated.
REQ-027 Full bypass: empty; enq_valid=11 with A,B; deq_take=2 -> same cycle deq_valid=11, deq_data={B,A}; next cycle count=0.
REQ-028 Partial bypass:
- cycle 1: enq A,B, take=1 -> A issued, B stored, count=1
- cycle 2: enq C,D, take=2 -> deq_data={C,B}, D stored, count=1
REQ-029 Fill and wrap:
- take=0, enq two per cycle -> count=2,4,6; at count=6 almost_full=1 and enq_ready=1; at count=8 enq_ready=0 and the enqueue is ignored
- then take=2 for 4 cycles -> issue order equals enqueue order, head wraps to 0, count=0
REQ-030 Flush: count=5 with flush=1, enq_valid=11, take=2 -> that cycle deq_valid=00 and enq_ready=0; next cycle count=0 and no entry issued.
REQ-031 Illegal requests: enq_valid=10 -> nothing accepted, count unchanged; count=1, no enq, deq_take=2 -> one entry issued, count=0.
REQ-032 BYPASS=0: empty; enq A,B with take=2 -> deq_valid=00; next cycle count=2, deq_data={B,A}.
